// File: rtl/fir.sv
// Four-tap FIR filter with serially loadable coefficients.
// Coefficients shift in on the sample bus while s_set_coeffs is high;
// accepted samples shift through a delay line, and the registered output
// is the saturated sum of products of the current taps and delay line.
module fir #(
    parameter int TAPS   = 4,
    parameter int DIN_W  = 6,
    parameter int DOUT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DIN_W-1:0]  s_axis_fir_tdata,
    input  logic                     s_axis_fir_tvalid,
    input  logic                     s_set_coeffs,
    input  logic                     s_axis_fir_tready,
    output logic signed [DOUT_W-1:0] m_axis_fir_tdata,
    output logic                     m_axis_fir_tvalid,
    output logic [3:0]               m_axis_fir_tkeep
);

    // Products are 2*DIN_W bits; two extra bits hold the four-term sum.
    localparam int SUM_W = 2 * DIN_W + 2;
    localparam logic signed [SUM_W-1:0] OUT_MAX = SUM_W'((2 ** (DOUT_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] OUT_MIN = -OUT_MAX - SUM_W'(1);

    logic signed [DIN_W-1:0]  r_h [TAPS];
    logic signed [DIN_W-1:0]  r_x [TAPS];
    logic                     r_accept;
    logic signed [DOUT_W-1:0] r_tdata;
    logic                     r_tvalid;
    logic signed [SUM_W-1:0]  w_sum;
    logic                     w_accept;

    // Clamp the full-width sum to the signed output range.
    function automatic logic signed [DOUT_W-1:0] sat(input logic signed [SUM_W-1:0] v);
        if (v > OUT_MAX) begin
            return OUT_MAX[DOUT_W-1:0];
        end else if (v < OUT_MIN) begin
            return OUT_MIN[DOUT_W-1:0];
        end else begin
            return v[DOUT_W-1:0];
        end
    endfunction

    // A coefficient load takes priority, so a sample offered alongside it is dropped.
    assign w_accept = !s_set_coeffs && s_axis_fir_tvalid && s_axis_fir_tready;

    // Full-width sum of products from the current taps and delay line.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < TAPS; i++) begin
            w_sum = w_sum + SUM_W'(r_h[i]) * SUM_W'(r_x[i]);
        end
    end

    // Coefficient shift register: new word enters at the top tap, h0 holds the oldest.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < TAPS; i++) begin
                r_h[i] <= '0;
            end
        end else if (s_set_coeffs) begin
            r_h[TAPS-1] <= s_axis_fir_tdata;
            for (int i = 0; i < TAPS - 1; i++) begin
                r_h[i] <= r_h[i+1];
            end
        end
    end

    // Sample delay line and accept flag; the line holds when nothing is accepted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < TAPS; i++) begin
                r_x[i] <= '0;
            end
            r_accept <= 1'b0;
        end else begin
            r_accept <= w_accept;
            if (w_accept) begin
                r_x[0] <= s_axis_fir_tdata;
                for (int i = 1; i < TAPS; i++) begin
                    r_x[i] <= r_x[i-1];
                end
            end
        end
    end

    // Output register advances only while downstream is ready.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
        end else if (s_axis_fir_tready) begin
            r_tdata  <= sat(w_sum);
            r_tvalid <= r_accept;
        end
    end

    assign m_axis_fir_tdata  = r_tdata;
    assign m_axis_fir_tvalid = r_tvalid;
    assign m_axis_fir_tkeep  = 4'b0001;

endmodule

// File: tb/tb_fir.sv
// Directed testbench for the four-tap FIR: reset, impulse response,
// saturation, handshake behaviour, load/sample collision, mid-stream reset.
module tb_fir;

    logic              clk;
    logic              reset;
    logic signed [5:0] s_axis_fir_tdata;
    logic              s_axis_fir_tvalid;
    logic              s_set_coeffs;
    logic              s_axis_fir_tready;
    logic signed [7:0] m_axis_fir_tdata;
    logic              m_axis_fir_tvalid;
    logic [3:0]        m_axis_fir_tkeep;

    int n_checks = 0;
    int n_errors = 0;

    fir dut (
        .clk               (clk),
        .reset             (reset),
        .s_axis_fir_tdata  (s_axis_fir_tdata),
        .s_axis_fir_tvalid (s_axis_fir_tvalid),
        .s_set_coeffs      (s_set_coeffs),
        .s_axis_fir_tready (s_axis_fir_tready),
        .m_axis_fir_tdata  (m_axis_fir_tdata),
        .m_axis_fir_tvalid (m_axis_fir_tvalid),
        .m_axis_fir_tkeep  (m_axis_fir_tkeep)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply inputs, then advance one rising edge and settle 1 time unit past it.
    task automatic step(input logic set, input logic vld, input logic rdy, input int d);
        logic [31:0] dv;
        dv = d;
        s_set_coeffs      = set;
        s_axis_fir_tvalid = vld;
        s_axis_fir_tready = rdy;
        s_axis_fir_tdata  = dv[5:0];
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int exp_d, input int exp_v);
        chk({tag, "_data"}, int'(m_axis_fir_tdata), exp_d);
        chk({tag, "_valid"}, int'(m_axis_fir_tvalid), exp_v);
    endtask

    task automatic load4(input int a, input int b, input int c, input int d);
        step(1'b1, 1'b0, 1'b1, a);
        step(1'b1, 1'b0, 1'b1, b);
        step(1'b1, 1'b0, 1'b1, c);
        step(1'b1, 1'b0, 1'b1, d);
    endtask

    int imp_exp [5] = '{7, -5, 27, 0, 0};

    initial begin
        reset             = 1'b0;
        s_set_coeffs      = 1'b0;
        s_axis_fir_tvalid = 1'b0;
        s_axis_fir_tready = 1'b0;
        s_axis_fir_tdata  = '0;

        // Reset for one edge.
        step(1'b0, 1'b0, 1'b0, 0);
        chk_out("reset", 0, 0);
        chk("reset_tkeep", int'(m_axis_fir_tkeep), 1);
        reset = 1'b1;

        // All-zero input gives zero output; valid follows two edges later.
        step(1'b0, 1'b1, 1'b1, 0);
        step(1'b0, 1'b1, 1'b1, 0);
        chk_out("zero_in", 0, 1);

        // Impulse response with coefficients 7, -5, 27, 0.
        load4(7, -5, 27, 0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 0);
        step(1'b0, 1'b1, 1'b1, 1);
        chk_out("imp_accept", 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b1, 0);
            chk_out($sformatf("imp%0d", i), imp_exp[i], 1);
        end
        chk("tkeep_run", int'(m_axis_fir_tkeep), 1);

        // Positive and negative saturation with all coefficients 31.
        load4(31, 31, 31, 31);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 31);
        chk_out("sat_pos", 127, 1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, -32);
        chk_out("sat_neg", -128, 1);

        // Coefficients h0..h3 = 1, 2, 3, 4; samples 1, 2, 3, 4.
        load4(1, 2, 3, 4);
        step(1'b0, 1'b1, 1'b1, 1);
        step(1'b0, 1'b1, 1'b1, 2);
        step(1'b0, 1'b1, 1'b1, 3);
        step(1'b0, 1'b1, 1'b1, 4);
        // Drop tvalid for one cycle: x=(4,3,2,1) -> 20.
        step(1'b0, 1'b0, 1'b1, 9);
        chk_out("gap_e5", 20, 1);
        step(1'b0, 1'b1, 1'b1, 5);
        chk_out("gap_e6", 20, 0);
        step(1'b0, 1'b1, 1'b1, 6);
        chk_out("gap_e7", 30, 1);

        // tready low for 3 cycles: output frozen, nothing accepted.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 7);
            chk_out($sformatf("stall%0d", i), 30, 1);
        end
        step(1'b0, 1'b1, 1'b1, 7);
        chk_out("resume1", 40, 0);
        step(1'b0, 1'b1, 1'b1, 0);
        chk_out("resume2", 50, 1);

        // Load and sample together: h becomes (2,3,4,2), x stays (0,7,6,5).
        step(1'b1, 1'b1, 1'b1, 2);
        chk_out("collide", 52, 1);
        step(1'b0, 1'b0, 1'b1, 0);
        chk_out("new_coef", 55, 0);

        // Exact output limits without clamping: x=(0,1,31,0) -> 127, x=(0,0,-32,0) -> -128.
        step(1'b0, 1'b1, 1'b1, 0);
        step(1'b0, 1'b1, 1'b1, 31);
        step(1'b0, 1'b1, 1'b1, 1);
        step(1'b0, 1'b1, 1'b1, 0);
        step(1'b0, 1'b0, 1'b1, 0);
        chk_out("edge_pos", 127, 1);
        step(1'b0, 1'b1, 1'b1, 0);
        step(1'b0, 1'b1, 1'b1, -32);
        step(1'b0, 1'b1, 1'b1, 0);
        step(1'b0, 1'b1, 1'b1, 0);
        step(1'b0, 1'b0, 1'b1, 0);
        chk_out("edge_neg", -128, 1);

        // Mid-stream reset clears coefficients.
        step(1'b0, 1'b1, 1'b1, 5);
        reset = 1'b0;
        step(1'b0, 1'b1, 1'b1, 5);
        chk_out("mid_reset", 0, 0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 5);
        chk_out("post_reset", 0, 1);
        // Reload h0=1 only: output becomes the newest sample.
        load4(1, 0, 0, 0);
        step(1'b0, 1'b1, 1'b1, 5);
        step(1'b0, 1'b1, 1'b1, 5);
        chk_out("reload", 5, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
